calc_arbiter: RTL

CALC_ARBITER -- requirements
Module: calc_arbiter

---
 rtl/calc_arbiter.sv | 121 ++++++++++++
 1 files changed

// File: rtl/calc_arbiter.sv
// calc_arbiter: two-requester round-robin front end for a shared arithmetic
// unit. One operation is in flight at a time: IDLE accepts, EXEC samples the
// arithmetic unit, RESP holds the result until the consumer takes it.
module calc_arbiter #(
  parameter int DATA_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [2:0]            req0_op,
  input  logic [DATA_W-1:0]     req0_a,
  input  logic [DATA_W-1:0]     req0_b,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [2:0]            req1_op,
  input  logic [DATA_W-1:0]     req1_a,
  input  logic [DATA_W-1:0]     req1_b,
  output logic [2:0]            au_op_sel,
  output logic [DATA_W-1:0]     au_a,
  output logic [DATA_W-1:0]     au_b,
  input  logic [2*DATA_W-1:0]   au_result,
  input  logic                  au_valid,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_id,
  output logic [2*DATA_W-1:0]   rsp_result,
  output logic                  rsp_err,
  output logic                  busy,
  output logic [7:0]            err_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state;
  logic                rr_ptr;     // requester that wins when both are valid
  logic [2:0]          lat_op;
  logic [DATA_W-1:0]   lat_a;
  logic [DATA_W-1:0]   lat_b;
  logic                lat_id;
  logic                grant_any;
  logic                grant_id;

  // Arbitration: a lone requester wins; on a tie the pointer decides.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = 1'b0;
    if (rst_n && (state == IDLE) && (req0_valid || req1_valid)) begin
      grant_any = 1'b1;
      if (req0_valid && req1_valid)
        grant_id = rr_ptr;
      else
        grant_id = req1_valid;
    end
    req0_ready = grant_any && !grant_id;
    req1_ready = grant_any &&  grant_id;
  end

  // The arithmetic unit always sees the latched operation.
  assign au_op_sel = lat_op;
  assign au_a      = lat_a;
  assign au_b      = lat_b;

  // Control FSM with registered response, busy and error counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rr_ptr     <= 1'b0;
      lat_op     <= '0;
      lat_a      <= '0;
      lat_b      <= '0;
      lat_id     <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_err    <= 1'b0;
      busy       <= 1'b0;
      err_count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            lat_op <= grant_id ? req1_op : req0_op;
            lat_a  <= grant_id ? req1_a  : req0_a;
            lat_b  <= grant_id ? req1_b  : req0_b;
            lat_id <= grant_id;
            rr_ptr <= ~grant_id;
            busy   <= 1'b1;
            state  <= EXEC;
          end
        end
        EXEC: begin
          rsp_result <= au_result;
          rsp_err    <= ~au_valid;
          rsp_id     <= lat_id;
          rsp_valid  <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            if (rsp_err && (err_count != 8'hFF))
              err_count <= err_count + 8'd1;
            state     <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
